// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file / scoreboard slice.
// Holds the default widths, the architectural register indices that
// have special meaning (zero register, jal link register) and the
// default saturation value of a per-register pending counter.
package regfile_scoreboard_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_CNT_W  = 2;

    // Hard-wired zero register and the jal link register.
    localparam int REG_ZERO = 0;
    localparam int REG_LINK = 31;

    // Maximum number of in-flight writers one counter can track.
    localparam int CNT_MAX = (2 ** DEFAULT_CNT_W) - 1;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of the write-back, decode and debug signals of the register file.
//   master : pipeline side (drives write-back, read indices, issue, flush)
//   slave  : register file side (drives BusA/BusB, dbg_data, Stall, Err)
// Signal names follow the pipeline they attach to.
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) ();

    // Write-back stage
    logic              WE;
    logic [ADDR_W-1:0] Rw;
    logic [DATA_W-1:0] BusW;
    logic              Ret_valid;

    // Decode stage
    logic [ADDR_W-1:0] Ra;
    logic [ADDR_W-1:0] Rb;
    logic              Ra_used;
    logic              Rb_used;
    logic              Iss_valid;
    logic [ADDR_W-1:0] Iss_rw;
    logic              Flush;
    logic [DATA_W-1:0] BusA;
    logic [DATA_W-1:0] BusB;
    logic              Stall;

    // Debug / status
    logic [ADDR_W-1:0] dbg_ra;
    logic [DATA_W-1:0] dbg_data;
    logic              Err;

    modport master (
        output WE, Rw, BusW, Ret_valid,
        output Ra, Rb, Ra_used, Rb_used, Iss_valid, Iss_rw, Flush, dbg_ra,
        input  BusA, BusB, Stall, dbg_data, Err
    );

    modport slave (
        input  WE, Rw, BusW, Ret_valid,
        input  Ra, Rb, Ra_used, Rb_used, Iss_valid, Iss_rw, Flush, dbg_ra,
        output BusA, BusB, Stall, dbg_data, Err
    );

endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Pending-writer counter for one architectural register.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   inc         a writer to this register is issued
//   dec         a writer to this register retires
//   clr         flush: drop every in-flight writer
//   cnt         number of writers in flight
//   busy        cnt != 0
//   last        cnt == 1 (the next retire frees the register)
//   err_pulse   issue on a full counter or retire on an empty one
module sb_counter
    import regfile_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             last,
    output logic             err_pulse
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_next  = cnt;
        err_pulse = 1'b0;
        if (clr) begin
            // A flush discards this cycle's issue/retire activity entirely.
            cnt_next = '0;
        end else if (inc && !dec) begin
            if (cnt == MAX) err_pulse = 1'b1;
            else            cnt_next  = cnt + ONE;
        end else if (dec && !inc) begin
            if (cnt == '0)  err_pulse = 1'b1;
            else            cnt_next  = cnt - ONE;
        end
        // inc && dec: one writer enters as another leaves, count unchanged.
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values, independent of block ordering.
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_next;
    end

    assign busy = (cnt != '0);
    assign last = (cnt == ONE);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass and per-register pending-write
// scoreboard.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   rf     regfile_scoreboard_if.slave:
//            write-back: WE, Rw, BusW, Ret_valid
//            decode:     Ra, Rb, Ra_used, Rb_used, Iss_valid, Iss_rw, Flush
//                        -> BusA, BusB, Stall (all combinational)
//            debug:      dbg_ra -> dbg_data (no bypass), Err (sticky)
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    regfile_scoreboard_if.slave rf
);

    localparam int                NREG     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is deliberately reset, so it maps to flops
            // rather than RAM; the architecture requires all registers to
            // read 0 straight after reset.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (rf.WE && rf.Rw != ZERO_IDX) begin
            regs[rf.Rw] <= rf.BusW;
        end
    end

    // Read ports: register 0 is hard-wired, and a write in the same cycle
    // is forwarded so decode sees the value write-back is committing.
    assign rf.BusA = (rf.Ra == ZERO_IDX)            ? '0      :
                     (rf.WE && rf.Rw == rf.Ra)      ? rf.BusW :
                                                      regs[rf.Ra];
    assign rf.BusB = (rf.Rb == ZERO_IDX)            ? '0      :
                     (rf.WE && rf.Rw == rf.Rb)      ? rf.BusW :
                                                      regs[rf.Rb];

    assign rf.dbg_data = (rf.dbg_ra == ZERO_IDX) ? '0 : regs[rf.dbg_ra];

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [NREG-1:0]            inc;
    logic [NREG-1:0]            dec;
    logic [NREG-1:0]            busy;
    logic [NREG-1:0]            last;
    logic [NREG-1:0]            err_pulse;
    logic [NREG-1:0]            pending;
    logic [NREG-1:0][CNT_W-1:0] cnt;

    for (genvar r = 0; r < NREG; r++) begin : g_sb
        localparam logic [ADDR_W-1:0] IDX     = ADDR_W'(r);
        localparam bit                IS_ZERO = (r == REG_ZERO);

        // Register 0 is never tracked: issues and retires to it are ignored.
        assign inc[r] = !IS_ZERO && rf.Iss_valid && (rf.Iss_rw == IDX);
        assign dec[r] = !IS_ZERO && rf.Ret_valid && (rf.Rw == IDX);

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .clr       (rf.Flush),
            .cnt       (cnt[r]),
            .busy      (busy[r]),
            .last      (last[r]),
            .err_pulse (err_pulse[r])
        );

        // The last writer retiring now is not a hazard: its data is on the
        // bypass, or (write suppressed) the old register value is correct.
        assign pending[r] = busy[r] && !(dec[r] && last[r]);
    end

    assign rf.Stall = (rf.Ra_used && pending[rf.Ra]) ||
                      (rf.Rb_used && pending[rf.Rb]);

    // Counter values are not needed by the datapath; they are kept as a
    // named array for debug visibility.
    logic unused_cnt;
    assign unused_cnt = ^cnt;

    // ------------------------------------------------------------------
    // Sticky protocol error
    // ------------------------------------------------------------------
    logic err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= err | (|err_pulse);
    end

    assign rf.Err = err;

endmodule
